uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-draining UART transmitter; optional even parity via UART_TX_PARITY_EN
module uart_tx #(
    parameter int SYS_CLK_FREQ = 50_000_000,
    parameter int BAUD_RATE    = 19200,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_pop,
    output logic                 tx,
    output logic                 busy
);
    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state_q, state_n;
    logic [CNT_W-1:0]      cnt_q, cnt_n;
    logic [BIT_W-1:0]      bit_q, bit_n;
    logic [STOP_W-1:0]     stop_q, stop_n;
    logic [DATA_BITS-1:0]  shift_q, shift_n;
    logic                  tx_n;
    logic                  busy_n;
    logic                  cnt_done;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_n;
`endif

    assign cnt_done = (cnt_q == CNT_LAST);

    // Pop is gated by reset so the FIFO never loses a word while the block is held in reset.
    assign fifo_pop = reset_n && (state_q == IDLE) && !fifo_empty;

    // Next-state, bit timing and line value; the line value is computed one edge early so tx is registered.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bit_n   = bit_q;
        stop_n  = stop_q;
        shift_n = shift_q;
        tx_n    = tx;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    shift_n = fifo_data;
                    tx_n    = 1'b0;
                    cnt_n   = '0;
                    state_n = START;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^fifo_data;
`endif
                end
            end
            START: begin
                if (cnt_done) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    tx_n    = shift_q[0];
                    state_n = DATA;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_done) begin
                    cnt_n = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_n    = par_q;
                        state_n = PARITY;
`else
                        tx_n    = 1'b1;
                        stop_n  = '0;
                        state_n = STOP;
`endif
                    end else begin
                        bit_n   = bit_q + 1'b1;
                        shift_n = shift_q >> 1;
                        tx_n    = shift_n[0];
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt_done) begin
                    cnt_n   = '0;
                    tx_n    = 1'b1;
                    stop_n  = '0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_done) begin
                    cnt_n = '0;
                    if (stop_q == STOP_LAST) begin
                        state_n = IDLE;
                    end else begin
                        stop_n = stop_q + 1'b1;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State, counters, shift register and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            bit_q   <= bit_n;
            stop_q  <= stop_n;
            shift_q <= shift_n;
            tx      <= tx_n;
            busy    <= busy_n;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (frame-level reference model plus vector table)
module tb_uart_tx;
    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 1 + 8 + P + 1;
    localparam int FRAME_LEN = NB * CPB;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_pop;
    logic       tx;
    logic       busy;

    logic [7:0] q[$];
    int n_cmp = 0;
    int n_err = 0;

    uart_tx #(
        .SYS_CLK_FREQ(16),
        .BAUD_RATE(1),
        .DATA_BITS(8),
        .STOP_BITS(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .fifo_pop(fifo_pop),
        .tx(tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO head: real word when non-empty, random garbage otherwise.
    task automatic refresh();
        fifo_empty = (q.size() == 0);
        fifo_data  = (q.size() != 0) ? q[0] : 8'($urandom);
    endtask

    // Expected line level for bit slot k of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (P == 1 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Reference model: a frame is a list of bit slots indexed by elapsed cycles since the pop edge.
    bit         m_active = 0;
    int         m_e = 0;
    logic [7:0] m_byte = 8'h00;
    bit         pop_dec;
    logic [7:0] pop_byte;
    always begin
        @(negedge clk);
        pop_dec = 0;
        pop_byte = 8'h00;
        if (!reset_n) begin
            chk("rst_tx", tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_pop", fifo_pop, 0);
        end else if (m_active) begin
            chk("frame_tx", tx, frame_bit(m_byte, (m_e - 1) / CPB));
            chk("frame_busy", busy, 1);
            chk("frame_pop", fifo_pop, 0);
        end else begin
            chk("idle_tx", tx, 1);
            chk("idle_busy", busy, 0);
            chk("idle_pop", fifo_pop, (q.size() != 0));
            if (q.size() != 0) begin
                pop_dec = 1;
                pop_byte = q[0];
            end
        end
        @(posedge clk);
        #1;
        if (!reset_n) begin
            m_active = 0;
        end else if (m_active) begin
            m_e++;
            if (m_e > FRAME_LEN) m_active = 0;
        end else if (pop_dec) begin
            m_active = 1;
            m_e = 1;
            m_byte = pop_byte;
            void'(q.pop_front());
        end
        refresh();
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
        logic       par;
    } vec_t;
    vec_t vecs[8];

    // One byte through an idle transmitter: pop count, busy length and mid-bit line samples.
    task automatic run_vec(input vec_t v);
        int pops = 0;
        int busy_cnt = 0;
        int t0 = -1;
        logic [NB-1:0] got = '0;
        logic [NB-1:0] exp;
`ifdef UART_TX_PARITY_EN
        exp = {v.line[9:1], v.par, v.line[0]};
`else
        exp = v.line;
`endif
        @(posedge clk);
        #2;
        q.push_back(v.data);
        refresh();
        for (int t = 0; t < FRAME_LEN + 20; t++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (fifo_pop) begin
                pops++;
                if (t0 < 0) t0 = t;
            end
            if (t0 >= 0 && (t - t0) >= 8 && ((t - t0 - 8) % CPB) == 0 && ((t - t0 - 8) / CPB) < NB)
                got[NB - 1 - (t - t0 - 8) / CPB] = tx;
        end
        chk($sformatf("vec_%02h_pops", v.data), pops, 1);
        chk($sformatf("vec_%02h_busy_len", v.data), busy_cnt, FRAME_LEN);
        chk($sformatf("vec_%02h_line", v.data), got, exp);
    endtask

    int  pt[3];
    int  np;
    bit  bt[700];
    int  lows;
    bit  found;

    initial begin
        vecs[0] = '{8'hA5, 10'b0_1010_0101_1, 1'b0};
        vecs[1] = '{8'h00, 10'b0_0000_0000_1, 1'b0};
        vecs[2] = '{8'hFF, 10'b0_1111_1111_1, 1'b0};
        vecs[3] = '{8'h55, 10'b0_1010_1010_1, 1'b0};
        vecs[4] = '{8'h07, 10'b0_1110_0000_1, 1'b1};
        vecs[5] = '{8'h03, 10'b0_1100_0000_1, 1'b0};
        vecs[6] = '{8'h01, 10'b0_1000_0000_1, 1'b1};
        vecs[7] = '{8'h80, 10'b0_0000_0001_1, 1'b1};

        #1 reset_n = 1'b0;
        refresh();
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (10) @(posedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-to-back: three preloaded words.
        @(posedge clk);
        #2;
        q.push_back(8'h00);
        q.push_back(8'hFF);
        q.push_back(8'h55);
        refresh();
        np = 0;
        for (int t = 0; t < 650; t++) begin
            @(negedge clk);
            bt[t] = busy;
            if (fifo_pop && np < 3) begin
                pt[np] = t;
                np++;
            end
        end
        chk("b2b_pop_count", np, 3);
        if (np == 3) begin
            chk("b2b_gap1", pt[1] - pt[0], FRAME_LEN + 1);
            chk("b2b_gap2", pt[2] - pt[1], FRAME_LEN + 1);
            lows = 0;
            for (int t = pt[0] + 1; t <= pt[2]; t++) if (!bt[t]) lows++;
            chk("b2b_busy_low_cycles", lows, 2);
        end

        // Async reset during data bit 3, then a quiet period, then a fresh frame.
        @(posedge clk);
        #2;
        q.push_back(8'h00);
        refresh();
        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (fifo_pop) found = 1;
        end
        chk("rst_test_pop_seen", found, 1);
        repeat (70) @(negedge clk);
        chk("pre_reset_tx_bit3", tx, 0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_pop", fifo_pop, 0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (100) @(posedge clk);
        #2;
        q.push_back(8'hC3);
        refresh();
        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (fifo_pop) found = 1;
        end
        chk("post_rst_pop_seen", found, 1);
        @(negedge clk);
        chk("post_rst_start_bit", tx, 0);
        chk("post_rst_busy", busy, 1);

        // Random traffic, with the FIFO head rewritten while frames are in flight.
        for (int it = 0; it < 25; it++) begin
            int gap;
            int nb;
            gap = $urandom_range(0, 250);
            nb  = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #2;
                if (busy && q.size() > 0 && $urandom_range(0, 7) == 0) begin
                    q[0] = 8'($urandom);
                    refresh();
                end
            end
            @(posedge clk);
            #2;
            for (int k = 0; k < nb; k++) q.push_back(8'($urandom));
            refresh();
        end
        for (int w = 0; w < 20000 && (q.size() != 0 || busy); w++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("random_drained", (q.size() == 0 && !busy), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
